fetch_decode_pipe_ctrl: RTL and testbench
=========================================

Name: fetch_decode_pipe_ctrl

Overview:
Sequential counterpart to the load-use hazard detection unit. It owns the PC register, the IF/ID pipeline register and the ID/EX control register, and applies the hazard unit's PC_Write, IF_ID_REG_Write and control_MUX_select outputs. It also applies branch flushes and closes the loop back to the hazard unit, providing IF_ID_rs1, IF_ID_rs2, ID_EXE_rd and ID_EXE_MemRead. It sits between instruction memory/decoder and the EX stage.

Parameters:
XLEN, 32, PC and instruction width
CTRL_W, 8, width of the decoder control bundle
MEMREAD_BIT, 3, index of the MemRead bit inside the control bundle
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, instruction inserted on flush (addi x0,x0,0)
CNT_W, 16, stall/flush counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
PC_Write  in  1  1 = PC may update; 0 = hold PC (hazard unit)
IF_ID_REG_Write  in  1  1 = IF/ID may load; 0 = hold (hazard unit)
control_MUX_select  in  1  1 = inject bubble (zero ctrl) into ID/EX (hazard unit)
branch_taken  in  1  redirect request from EX
branch_target  in  XLEN  redirect PC
instr_in  in  XLEN  instruction memory data for current pc
ctrl_in  in  CTRL_W  decoder control bundle for IF_ID_instr
pc  out  XLEN  fetch address
IF_ID_pc  out  XLEN  PC of instruction in decode
IF_ID_instr  out  XLEN  instruction in decode
IF_ID_valid  out  1  decode slot holds a real instruction
IF_ID_rs1  out  5  IF_ID_instr[19:15] (combinational)
IF_ID_rs2  out  5  IF_ID_instr[24:20] (combinational)
ID_EXE_ctrl  out  CTRL_W  registered control bundle in EX
ID_EXE_rd  out  5  registered rd (instr[11:7]) in EX
ID_EXE_MemRead  out  1  ID_EXE_ctrl[MEMREAD_BIT]
stall_count  out  CNT_W  saturating count of stall cycles
flush_count  out  CNT_W  saturating count of flush cycles

Behaviour:
- Reset, sync and active-high:
  - pc=RESET_PC, IF_ID_pc=0, IF_ID_instr=NOP_INSTR, IF_ID_valid=0.
  - ID_EXE_ctrl=0, ID_EXE_rd=0, both counters=0.
  - Reset overrides every other input in the same cycle.
- Per-cycle priority: reset > branch_taken (flush) > stall > normal.
- Flush (branch_taken=1):
  - pc<=branch_target; IF_ID_instr<=NOP_INSTR, IF_ID_valid<=0, IF_ID_pc<=0.
  - ID_EXE_ctrl<=0, ID_EXE_rd<=0.
  - PC_Write, IF_ID_REG_Write and control_MUX_select are ignored.
  - flush_count increments.
- Stall: branch_taken=0 and PC_Write=0 and IF_ID_REG_Write=0:
  - pc and all IF/ID fields hold.
  - ID/EX receives a bubble when control_MUX_select=1 (ctrl=0, rd=0).
  - stall_count increments.
- Normal: PC_Write=1 and IF_ID_REG_Write=1:
  - pc<=pc+4, mod 2^XLEN, wrapping at all-ones.
  - IF_ID_pc<=pc, IF_ID_instr<=instr_in, IF_ID_valid<=1.
  - ID_EXE_ctrl<=(control_MUX_select ? 0 : (IF_ID_valid ? ctrl_in : 0)); ID_EXE_rd<=IF_ID_instr[11:7] when the ctrl is not zeroed, else 0.
- Mixed enables (exactly one of PC_Write, IF_ID_REG_Write is 0) are legal:
  - Each register group obeys its own enable independently.
  - No counter increments.
- ID/EX always loads every cycle; it has no enable.
- Latency:
  - The instruction fetched at pc appears on IF_ID_instr 1 cycle later.
  - Its ctrl appears on ID_EXE_ctrl 2 cycles later, absent stalls.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- IF_ID_rs1, IF_ID_rs2 and ID_EXE_MemRead are pure decodes of registered state, with no input-to-output combinational path.

Test Plan:
- Reset: hold reset 2 cycles with branch_taken=1 and instr_in=32'hDEADBEEF -> pc=0, IF_ID_valid=0, IF_ID_instr=32'h13, ID_EXE_ctrl=0, counters=0.
- Straight line: enables=1, select=0, 3 cycles, instr_in=32'h00208093 -> pc 0→4→8→C; IF_ID_pc=8; IF_ID_rs1=1, IF_ID_rs2=2; ID_EXE_rd=1 one cycle after that instruction reaches decode.
- Load-use: ID/EX holds lw x2 (ctrl bit3=1), decode holds rs1=2; drive PC_Write=0, IF_ID_REG_Write=0, select=1 for 1 cycle -> pc and IF_ID_instr unchanged, ID_EXE_ctrl=0, ID_EXE_MemRead=0, ID_EXE_rd=0, stall_count=1; next normal cycle resumes at pc+4.
- Flush during stall: branch_taken=1, branch_target=32'h100, PC_Write=0 -> pc=32'h100, IF_ID_valid=0, IF_ID_instr=32'h13, ID_EXE_ctrl=0, flush_count=1, stall_count unchanged.
- Wrap/saturation: branch_target=32'hFFFF_FFFC then a normal cycle -> pc=0. With CNT_W=4, 20 stall cycles -> stall_count=15.
- Reset mid-stall: PC_Write=0 and reset=1 -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/fetch_decode_pipe_ctrl.sv
// Fetch/decode pipeline control: PC, IF/ID and ID/EX registers driven by the
// load-use hazard unit's enables, with branch flush and stall/flush statistics.
module fetch_decode_pipe_ctrl #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     CTRL_W      = 8,
   parameter int unsigned     MEMREAD_BIT = 3,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter logic [XLEN-1:0] NOP_INSTR   = XLEN'(32'h0000_0013),
   parameter int unsigned     CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PC_Write,
   input  logic              IF_ID_REG_Write,
   input  logic              control_MUX_select,
   input  logic              branch_taken,
   input  logic [XLEN-1:0]   branch_target,
   input  logic [XLEN-1:0]   instr_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   output logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   IF_ID_pc,
   output logic [XLEN-1:0]   IF_ID_instr,
   output logic              IF_ID_valid,
   output logic [4:0]        IF_ID_rs1,
   output logic [4:0]        IF_ID_rs2,
   output logic [CTRL_W-1:0] ID_EXE_ctrl,
   output logic [4:0]        ID_EXE_rd,
   output logic              ID_EXE_MemRead,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   logic stall_cyc;
   logic bubble;

   // A full stall needs both hazard enables low; mixed enables are not counted.
   always_comb begin
      stall_cyc = !branch_taken && !PC_Write && !IF_ID_REG_Write;
      bubble    = control_MUX_select || !IF_ID_valid;
   end

   // Fetch address.
   always_ff @(posedge clk) begin
      if (reset)             pc <= RESET_PC;
      else if (branch_taken) pc <= branch_target;
      else if (PC_Write)     pc <= pc + XLEN'(4);
   end

   // IF/ID register; a flush leaves a NOP marked invalid in decode.
   always_ff @(posedge clk) begin
      if (reset || branch_taken) begin
         IF_ID_pc    <= '0;
         IF_ID_instr <= NOP_INSTR;
         IF_ID_valid <= 1'b0;
      end else if (IF_ID_REG_Write) begin
         IF_ID_pc    <= pc;
         IF_ID_instr <= instr_in;
         IF_ID_valid <= 1'b1;
      end
   end

   // ID/EX register loads every cycle; bubbles and invalid slots carry zero ctrl.
   always_ff @(posedge clk) begin
      if (reset || branch_taken || bubble) begin
         ID_EXE_ctrl <= '0;
         ID_EXE_rd   <= '0;
      end else begin
         ID_EXE_ctrl <= ctrl_in;
         ID_EXE_rd   <= IF_ID_instr[11:7];
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_cyc && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
         if (branch_taken && (flush_count != '1))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

   // Feedback to the hazard unit, decoded from registered state only.
   always_comb begin
      IF_ID_rs1      = IF_ID_instr[19:15];
      IF_ID_rs2      = IF_ID_instr[24:20];
      ID_EXE_MemRead = ID_EXE_ctrl[MEMREAD_BIT];
   end

endmodule

// File: tb/tb_fetch_decode_pipe_ctrl.sv
// Bench for fetch_decode_pipe_ctrl: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_fetch_decode_pipe_ctrl;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned CTRL_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int          CNT_MAX = 15;

   logic              clk = 1'b0;
   logic              reset;
   logic              PC_Write;
   logic              IF_ID_REG_Write;
   logic              control_MUX_select;
   logic              branch_taken;
   logic [XLEN-1:0]   branch_target;
   logic [XLEN-1:0]   instr_in;
   logic [CTRL_W-1:0] ctrl_in;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   IF_ID_pc;
   logic [XLEN-1:0]   IF_ID_instr;
   logic              IF_ID_valid;
   logic [4:0]        IF_ID_rs1;
   logic [4:0]        IF_ID_rs2;
   logic [CTRL_W-1:0] ID_EXE_ctrl;
   logic [4:0]        ID_EXE_rd;
   logic              ID_EXE_MemRead;
   logic [CNT_W-1:0]  stall_count;
   logic [CNT_W-1:0]  flush_count;

   fetch_decode_pipe_ctrl #(.CNT_W(CNT_W)) dut (
      .clk                (clk),
      .reset              (reset),
      .PC_Write           (PC_Write),
      .IF_ID_REG_Write    (IF_ID_REG_Write),
      .control_MUX_select (control_MUX_select),
      .branch_taken       (branch_taken),
      .branch_target      (branch_target),
      .instr_in           (instr_in),
      .ctrl_in            (ctrl_in),
      .pc                 (pc),
      .IF_ID_pc           (IF_ID_pc),
      .IF_ID_instr        (IF_ID_instr),
      .IF_ID_valid        (IF_ID_valid),
      .IF_ID_rs1          (IF_ID_rs1),
      .IF_ID_rs2          (IF_ID_rs2),
      .ID_EXE_ctrl        (ID_EXE_ctrl),
      .ID_EXE_rd          (ID_EXE_rd),
      .ID_EXE_MemRead     (ID_EXE_MemRead),
      .stall_count        (stall_count),
      .flush_count        (flush_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference state: architectural view of the pipeline.
   logic [31:0] m_pc, m_ifpc, m_ifinstr, m_rd;
   logic        m_valid;
   logic [7:0]  m_ctrl;
   int          m_stall, m_flush;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [31:0] instr;
      instr = m_ifinstr;
      chk("pc",       pc, m_pc);
      chk("ifid_pc",  IF_ID_pc, m_ifpc);
      chk("ifid_ins", IF_ID_instr, m_ifinstr);
      chk("ifid_vld", 32'(IF_ID_valid), 32'(m_valid));
      chk("rs1",      32'(IF_ID_rs1), 32'(instr[19:15]));
      chk("rs2",      32'(IF_ID_rs2), 32'(instr[24:20]));
      chk("ex_ctrl",  32'(ID_EXE_ctrl), 32'(m_ctrl));
      chk("ex_rd",    32'(ID_EXE_rd), m_rd);
      chk("memread",  32'(ID_EXE_MemRead), 32'(m_ctrl[3]));
      chk("stalls",   32'(stall_count), 32'(m_stall));
      chk("flushes",  32'(flush_count), 32'(m_flush));
   endtask

   // Advance one clock: predict from the rules, then compare after the edge.
   task automatic cycle();
      logic [31:0] n_pc, n_ifpc, n_ifinstr, n_rd, old_instr;
      logic        n_valid;
      logic [7:0]  n_ctrl;
      int          n_stall, n_flush;
      old_instr = m_ifinstr;
      n_pc = m_pc; n_ifpc = m_ifpc; n_ifinstr = m_ifinstr; n_valid = m_valid;
      n_stall = m_stall; n_flush = m_flush;
      if (reset) begin
         n_pc = 0; n_ifpc = 0; n_ifinstr = 32'h13; n_valid = 0;
         n_ctrl = 0; n_rd = 0; n_stall = 0; n_flush = 0;
      end else if (branch_taken) begin
         n_pc = branch_target; n_ifpc = 0; n_ifinstr = 32'h13; n_valid = 0;
         n_ctrl = 0; n_rd = 0;
         n_flush = (m_flush + 1 > CNT_MAX) ? CNT_MAX : m_flush + 1;
      end else begin
         if (PC_Write) n_pc = m_pc + 32'd4;
         if (IF_ID_REG_Write) begin
            n_ifpc = m_pc; n_ifinstr = instr_in; n_valid = 1;
         end
         if (control_MUX_select || !m_valid) begin
            n_ctrl = 0; n_rd = 0;
         end else begin
            n_ctrl = ctrl_in; n_rd = 32'(old_instr[11:7]);
         end
         if (!PC_Write && !IF_ID_REG_Write)
            n_stall = (m_stall + 1 > CNT_MAX) ? CNT_MAX : m_stall + 1;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_ifpc = n_ifpc; m_ifinstr = n_ifinstr; m_valid = n_valid;
      m_ctrl = n_ctrl; m_rd = n_rd; m_stall = n_stall; m_flush = n_flush;
      check_all();
   endtask

   task automatic drive(input logic rst, input logic pcw, input logic ifw, input logic sel,
                        input logic br, input logic [31:0] tgt,
                        input logic [31:0] ins, input logic [7:0] ctl);
      reset = rst; PC_Write = pcw; IF_ID_REG_Write = ifw; control_MUX_select = sel;
      branch_taken = br; branch_target = tgt; instr_in = ins; ctrl_in = ctl;
   endtask

   logic [31:0] saved_pc, saved_instr;

   initial begin
      m_pc = 0; m_ifpc = 0; m_ifinstr = 32'h13; m_valid = 0;
      m_ctrl = 0; m_rd = 0; m_stall = 0; m_flush = 0;

      // Reset dominates a simultaneous branch.
      drive(1, 1, 1, 0, 1, 32'h123, 32'hDEADBEEF, 8'hFF);
      cycle(); cycle();
      chk("rst_pc", pc, 32'h0);
      chk("rst_ins", IF_ID_instr, 32'h13);
      chk("rst_vld", 32'(IF_ID_valid), 32'h0);

      // Straight-line fetch.
      drive(0, 1, 1, 0, 0, 32'h0, 32'h00208093, 8'h01);
      repeat (3) cycle();
      chk("sl_pc", pc, 32'hC);
      chk("sl_ifpc", IF_ID_pc, 32'h8);
      chk("sl_rs1", 32'(IF_ID_rs1), 32'd1);
      chk("sl_rs2", 32'(IF_ID_rs2), 32'd2);
      chk("sl_rd", 32'(ID_EXE_rd), 32'd1);

      // Load-use: lw x2 into EX while add x2,x2,x2 sits in decode.
      drive(0, 1, 1, 0, 0, 32'h0, 32'h00002103, 8'h01);
      cycle();
      drive(0, 1, 1, 0, 0, 32'h0, 32'h00210133, 8'h08);
      cycle();
      chk("lu_memrd", 32'(ID_EXE_MemRead), 32'd1);
      chk("lu_rs1", 32'(IF_ID_rs1), 32'd2);
      saved_pc = pc; saved_instr = IF_ID_instr;
      drive(0, 0, 0, 1, 0, 32'h0, 32'h00000033, 8'h08);
      cycle();
      chk("st_pc", pc, saved_pc);
      chk("st_ins", IF_ID_instr, saved_instr);
      chk("st_ctrl", 32'(ID_EXE_ctrl), 32'h0);
      chk("st_rd", 32'(ID_EXE_rd), 32'h0);
      chk("st_cnt", 32'(stall_count), 32'd1);
      drive(0, 1, 1, 0, 0, 32'h0, 32'h00000033, 8'h02);
      cycle();
      chk("resume_pc", pc, saved_pc + 32'd4);

      // Flush wins over a concurrent stall.
      drive(0, 0, 0, 1, 1, 32'h100, 32'h00000033, 8'h02);
      cycle();
      chk("fl_pc", pc, 32'h100);
      chk("fl_vld", 32'(IF_ID_valid), 32'h0);
      chk("fl_ins", IF_ID_instr, 32'h13);
      chk("fl_cnt", 32'(flush_count), 32'd1);
      chk("fl_stall", 32'(stall_count), 32'd1);

      // PC wraps at the top of the address space.
      drive(0, 1, 1, 0, 1, 32'hFFFF_FFFC, 32'h0, 8'h0);
      cycle();
      drive(0, 1, 1, 0, 0, 32'h0, 32'h00000093, 8'h01);
      cycle();
      chk("wrap_pc", pc, 32'h0);

      // Stall counter saturates.
      drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 8'h0);
      repeat (20) cycle();
      chk("sat_stall", 32'(stall_count), 32'd15);

      // Reset in the middle of a stall.
      drive(1, 0, 0, 1, 0, 32'h0, 32'h0, 8'h0);
      cycle();
      chk("rst2_pc", pc, 32'h0);
      chk("rst2_stall", 32'(stall_count), 32'h0);

      // Random traffic, including mixed enables.
      for (int i = 0; i < 500; i++) begin
         drive(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0), $urandom & 32'hFFFF_FFFC, $urandom, 8'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            PC_Write = 1'b1; IF_ID_REG_Write = 1'b1;
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
